ifetch_unit: RTL and testbench

Instruction-fetch initiator for the single-core pipeline and the request side of the `imem` read port. After reset it sequences the boot-time instruction load, then drives `inst_mem_addr` and `imem_enable` word by word. It captures the returned `inst_CCD` words into a 2-entry buffer and hands them to decode with a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch at the new PC.

---
 rtl/ifetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_ifetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ifetch_unit: boot-load sequencer, imem fetch issue and 2-entry fetch buffer.
// Optional IFETCH_HALT_EN stops fetch on EBREAK.              Revision: 1.0
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter int                ADDR_W      = 11,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                LOAD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_enable,
  output logic              load_imem,
  output logic [ADDR_W-1:0] inst_mem_addr,
  input  logic [31:0]       inst_CCD,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  localparam int                CNT_W    = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

`ifdef IFETCH_HALT_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  typedef enum logic [1:0] {
    BOOT_OFF  = 2'd0,
    BOOT_LOAD = 2'd1,
    RUN       = 2'd2,
    HALT      = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    BOOT_OFF  = 2'd0,
    BOOT_LOAD = 2'd1,
    RUN       = 2'd2
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
  logic              infl_epoch_q, infl_epoch_d;
  logic              epoch_q, epoch_d;
  logic [1:0]        count_q, count_d;
  logic [31:0]       buf_inst_q [2];
  logic [31:0]       buf_inst_d [2];
  logic [ADDR_W-1:0] buf_pc_q [2];
  logic [ADDR_W-1:0] buf_pc_d [2];

  logic       pop;
  logic       capture;
  logic       credit;
  logic [1:0] cnt_after;
  logic       unused_redirect_lsbs;

  assign out_valid     = (count_q != 2'd0);
  assign out_inst      = out_valid ? buf_inst_q[0] : 32'd0;
  assign out_pc        = out_valid ? buf_pc_q[0] : '0;
  assign inst_mem_addr = addr_q;
  assign imem_enable   = (state_q != BOOT_OFF);
  assign load_imem     = (state_q == BOOT_LOAD);

  assign pop     = out_valid && out_ready;
  // Responses issued before the last redirect carry the old epoch and are dropped.
  assign capture = infl_q && (infl_epoch_q == epoch_q);
  // Buffer slots are reserved at issue time, so a pop frees one for this cycle.
  assign credit  = (({1'b0, count_q} + {2'b00, infl_q}) < 3'd2) || pop;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

`ifdef IFETCH_HALT_EN
  logic halt_now;
  assign halt_now = capture && (inst_CCD == EBREAK);
  assign halted   = (state_q == HALT);
`else
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    infl_d       = 1'b0;
    infl_pc_d    = infl_pc_q;
    infl_epoch_d = infl_epoch_q;
    epoch_d      = epoch_q;
    count_d      = count_q;
    buf_inst_d   = buf_inst_q;
    buf_pc_d     = buf_pc_q;
    cnt_after    = count_q;

    case (state_q)
      BOOT_OFF: begin
        state_d = BOOT_LOAD;
        cnt_d   = '0;
      end

      BOOT_LOAD: begin
        if (cnt_q == CNT_LAST) begin
          // The edge that leaves boot load already issues the first fetch.
          state_d      = RUN;
          addr_d       = RESET_PC;
          pc_d         = RESET_PC + PC_STEP;
          infl_d       = 1'b1;
          infl_pc_d    = RESET_PC;
          infl_epoch_d = epoch_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_after = count_q - {1'b0, pop};
        if (pop) begin
          buf_inst_d[0] = buf_inst_q[1];
          buf_pc_d[0]   = buf_pc_q[1];
        end
        if (capture) begin
          buf_inst_d[cnt_after[0]] = inst_CCD;
          buf_pc_d[cnt_after[0]]   = infl_pc_q;
          count_d                  = cnt_after + 2'd1;
        end else begin
          count_d = cnt_after;
        end

`ifdef IFETCH_HALT_EN
        if (halt_now) begin
          state_d = HALT;
        end
`endif

        if ((state_d == RUN) && credit && !redirect_valid) begin
          addr_d       = pc_q;
          pc_d         = pc_q + PC_STEP;
          infl_d       = 1'b1;
          infl_pc_d    = pc_q;
          infl_epoch_d = epoch_q;
        end

        if (redirect_valid) begin
          count_d = 2'd0;
          epoch_d = ~epoch_q;
          pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
          infl_d  = 1'b0;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT_OFF;
      cnt_q        <= '0;
      pc_q         <= '0;
      addr_q       <= '0;
      infl_q       <= 1'b0;
      infl_pc_q    <= '0;
      infl_epoch_q <= 1'b0;
      epoch_q      <= 1'b0;
      count_q      <= 2'd0;
      buf_inst_q   <= '{default: '0};
      buf_pc_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      infl_q       <= infl_d;
      infl_pc_q    <= infl_pc_d;
      infl_epoch_q <= infl_epoch_d;
      epoch_q      <= epoch_d;
      count_q      <= count_d;
      buf_inst_q   <= buf_inst_d;
      buf_pc_q     <= buf_pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ifetch_unit: scoreboard bench for ifetch_unit with a combinational imem.
//                                                             Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

  localparam int          ADDR_W = 11;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef IFETCH_HALT_EN
  localparam logic        HALT_EN = 1'b1;
`else
  localparam logic        HALT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_enable;
  logic              load_imem;
  logic [ADDR_W-1:0] inst_mem_addr;
  logic [31:0]       inst_CCD;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic armed  = 1'b0;

  always #5 clk = ~clk;

  // Memory image: address tagged into each word; 0x00C becomes EBREAK once armed.
  assign inst_CCD = (armed && (inst_mem_addr == 11'h00C)) ? EBREAK
                  : (32'hC0DE_0000 | {21'd0, inst_mem_addr});

  ifetch_unit #(
    .ADDR_W      (ADDR_W),
    .RESET_PC    (11'h000),
    .LOAD_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_enable    (imem_enable),
    .load_imem      (load_imem),
    .inst_mem_addr  (inst_mem_addr),
    .inst_CCD       (inst_CCD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return (armed && (a == 11'h00C)) ? EBREAK : (32'hC0DE_0000 | {21'd0, a});
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [ADDR_W-1:0] start, input int n);
    logic [ADDR_W-1:0] pc;
    pc = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: pc, inst: mem_word(pc)});
      pc = pc + 11'd4;
    end
  endtask

  task automatic check_reset_values();
    check("rst_imem_enable", 32'(imem_enable), 32'd0);
    check("rst_load_imem",   32'(load_imem),   32'd0);
    check("rst_addr",        32'(inst_mem_addr), 32'd0);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_out_inst",    out_inst,         32'd0);
    check("rst_out_pc",      32'(out_pc),      32'd0);
    check("rst_halted",      32'(halted),      32'd0);
  endtask

  // Called at #1 after the edge on which rst_n was released; ends one cycle
  // after the first RUN fetch.
  task automatic boot_seq();
    check("boot_off_load", 32'(load_imem), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check("boot_load_imem",   32'(load_imem),     32'd1);
      check("boot_imem_enable", 32'(imem_enable),   32'd1);
      check("boot_addr_idle",   32'(inst_mem_addr), 32'd0);
    end
    tick(1);
    check("run_load_low",     32'(load_imem),     32'd0);
    check("run_imem_enable",  32'(imem_enable),   32'd1);
    check("first_fetch_addr", 32'(inst_mem_addr), 32'h000);
    check("first_valid_low",  32'(out_valid),     32'd0);
    tick(1);
    check("first_out_valid",   32'(out_valid),     32'd1);
    check("first_out_pc",      32'(out_pc),        32'h000);
    check("second_fetch_addr", 32'(inst_mem_addr), 32'h004);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc 0x%03h expected no transfer", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("out_pc",   32'(out_pc), 32'(e.pc));
        check("out_inst", out_inst,    e.inst);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check_reset_values();

    // Boot, steady stream, 5-cycle stall, then redirect with two words buffered.
    push_seq(11'h000, 7);
    rst_n = 1'b1;
    boot_seq();
    tick(1);
    check("steady_addr", 32'(inst_mem_addr), 32'h008);
    tick(3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("stall_valid", 32'(out_valid),     32'd1);
      check("stall_pc",    32'(out_pc),        32'h010);
      check("stall_inst",  out_inst,           mem_word(11'h010));
      check("stall_addr",  32'(inst_mem_addr), 32'h014);
    end
    out_ready = 1'b1;
    tick(1);
    check("resume_addr", 32'(inst_mem_addr), 32'h018);
    check("resume_pc",   32'(out_pc),        32'h014);
    tick(2);
    out_ready = 1'b0;
    tick(1);
    check("full_pc", 32'(out_pc), 32'h01C);
    redirect_valid = 1'b1;
    redirect_pc    = 11'h123;
    tick(1);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    push_seq(11'h120, 2);
    check("flush_valid", 32'(out_valid), 32'd0);
    tick(1);
    check("redir_addr",      32'(inst_mem_addr), 32'h120);
    check("redir_valid_low", 32'(out_valid),     32'd0);
    tick(1);
    check("redir_out_valid", 32'(out_valid), 32'd1);
    check("redir_out_pc",    32'(out_pc),    32'h120);

    // Redirect while one word is buffered and one is in flight; wrap at top.
    tick(2);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 11'h7FC;
    push_seq(11'h7FC, 3);
    tick(1);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    check("flush2_valid", 32'(out_valid), 32'd0);
    tick(1);
    check("wrap_addr0", 32'(inst_mem_addr), 32'h7FC);
    tick(1);
    check("wrap_addr1", 32'(inst_mem_addr), 32'h000);
    tick(1);
    check("wrap_addr2", 32'(inst_mem_addr), 32'h004);
    tick(2);

    // Asynchronous reset mid-run, then a second boot with EBREAK at 0x00C.
    rst_n = 1'b0;
    #1;
    check_reset_values();
    check("drain_before_reset", 32'(exp_q.size()), 32'd0);
    tick(2);
    armed = 1'b1;
    push_seq(11'h000, HALT_EN ? 4 : 5);
    rst_n = 1'b1;
    boot_seq();
    tick(3);
    check("halt_flag", 32'(halted), 32'(HALT_EN));
    tick(2);
    check("halt_addr", 32'(inst_mem_addr), HALT_EN ? 32'h00C : 32'h018);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 11'h041;
    push_seq(11'h040, 2);
    tick(1);
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    check("resume_halted", 32'(halted),    32'd0);
    check("resume_valid",  32'(out_valid), 32'd0);
    tick(1);
    check("resume_fetch", 32'(inst_mem_addr), 32'h040);
    tick(3);
    out_ready = 1'b0;
    tick(2);
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
